// File: rtl/pipe_multiplier.sv
// Pipelined WIDTH x WIDTH multiplier: carry-save row compression spread over STAGES valid-tagged
// register stages, then a final carry-propagate add. Define PIPE_MULT_SIGNED_EN for two's complement.

module pipe_multiplier #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   o,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int unsigned PW = 2 * WIDTH;
    // One row per partial product plus one row for the Baugh-Wooley correction constant.
    localparam int unsigned R  = WIDTH + 1;

    typedef logic [R-1:0][PW-1:0] rows_t;

    function automatic int unsigned num_levels(input int unsigned rows);
        int unsigned n;
        int unsigned cnt;
        n   = rows;
        cnt = 0;
        while (n > 2) begin
            n   = 2 * (n / 3) + n % 3;
            cnt = cnt + 1;
        end
        return cnt;
    endfunction

    localparam int unsigned NLEV = num_levels(R);
    localparam int unsigned LPS  = (NLEV + STAGES - 1) / STAGES;

    // Compression levels completed by the end of stage k.
    function automatic int unsigned levels_done(input int unsigned k);
        int unsigned n;
        n = (k + 1) * LPS;
        return (n < NLEV) ? n : NLEV;
    endfunction

    function automatic rows_t gen_pp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        rows_t r;
        r = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            for (int j = 0; j < int'(WIDTH); j++) begin
`ifdef PIPE_MULT_SIGNED_EN
                // Cross terms with exactly one sign bit are complemented.
                r[i][i+j] = (a[j] & b[i]) ^ ((i == int'(WIDTH) - 1) != (j == int'(WIDTH) - 1));
`else
                r[i][i+j] = a[j] & b[i];
`endif
            end
        end
`ifdef PIPE_MULT_SIGNED_EN
        r[R-1][WIDTH] = 1'b1;
        r[R-1][PW-1]  = 1'b1;
`endif
        return r;
    endfunction

    // One level of full adders: each group of three rows becomes a sum row and a carry row,
    // results packed to the front so unused rows stay zero.
    function automatic rows_t csa_level(input rows_t a);
        rows_t          r;
        logic [PW-1:0]  s;
        logic [PW-1:0]  c;
        r = '0;
        for (int g = 0; g < int'(R / 3); g++) begin
            s = a[3*g] ^ a[3*g+1] ^ a[3*g+2];
            c = (a[3*g] & a[3*g+1]) | (a[3*g] & a[3*g+2]) | (a[3*g+1] & a[3*g+2]);
            r[2*g]   = s;
            r[2*g+1] = c << 1;
        end
        for (int t = 0; t < int'(R % 3); t++) begin
            r[2*int'(R/3)+t] = a[3*int'(R/3)+t];
        end
        return r;
    endfunction

    function automatic rows_t reduce(input rows_t a, input int unsigned levels);
        rows_t r;
        r = a;
        for (int unsigned l = 0; l < levels; l++) begin
            r = csa_level(r);
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] cpa(input rows_t a);
        return a[0] + a[1];
    endfunction

    logic          adv;
    logic [PW-1:0] o_d, o_q;
    logic          out_valid_d, out_valid_q;
    logic          stage_busy;

    always_comb begin
        adv      = !out_valid_q || out_ready;
        in_ready = adv;
    end

    generate
        if (STAGES == 1) begin : g_single
            always_comb begin
                o_d         = cpa(reduce(gen_pp(x, y), NLEV));
                out_valid_d = in_valid;
                stage_busy  = 1'b0;
            end
        end else begin : g_multi
            rows_t             stg_d [STAGES-1];
            rows_t             stg_q [STAGES-1];
            logic [STAGES-2:0] vld_d;
            logic [STAGES-2:0] vld_q;

            always_comb begin
                stg_d[0] = reduce(gen_pp(x, y), levels_done(0));
                vld_d[0] = in_valid;
                for (int k = 1; k < int'(STAGES) - 1; k++) begin
                    stg_d[k] = reduce(stg_q[k-1], levels_done(k) - levels_done(k - 1));
                    vld_d[k] = vld_q[k-1];
                end
                o_d         = cpa(reduce(stg_q[STAGES-2], NLEV - levels_done(STAGES - 2)));
                out_valid_d = vld_q[STAGES-2];
                stage_busy  = |vld_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                end else if (adv) begin
                    vld_q <= vld_d;
                end
            end

            // Data rows carry no reset; their valid bits gate every use.
            always_ff @(posedge clk) begin
                if (adv) begin
                    for (int k = 0; k < int'(STAGES) - 1; k++) begin
                        stg_q[k] <= stg_d[k];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q         <= '0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            o_q         <= o_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        o         = o_q;
        out_valid = out_valid_q;
        busy      = stage_busy | out_valid_q;
    end

endmodule

// File: tb/tb_pipe_multiplier.sv
// Self-checking bench for pipe_multiplier: directed 4-bit/2-stage scenarios plus randomized
// 8-bit/3-stage traffic against an arithmetic reference model with an in-order scoreboard.

module tb_pipe_multiplier;

    localparam int LAT8 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  x4 = '0, y4 = '0;
    logic        in_valid4 = 1'b0, out_ready4 = 1'b1;
    logic        in_ready4, out_valid4, busy4;
    logic [7:0]  o4;

    logic [7:0]  x8 = '0, y8 = '0;
    logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
    logic        in_ready8, out_valid8, busy8;
    logic [15:0] o8;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] p;
        int          due;
    } entry_t;
    entry_t q[$];

    always #5 clk = ~clk;

    pipe_multiplier #(.WIDTH(4), .STAGES(2)) u_dut4 (
        .clk(clk), .rst(rst), .x(x4), .y(y4), .in_valid(in_valid4), .in_ready(in_ready4),
        .o(o4), .out_valid(out_valid4), .out_ready(out_ready4), .busy(busy4)
    );

    pipe_multiplier #(.WIDTH(8), .STAGES(3)) u_dut8 (
        .clk(clk), .rst(rst), .x(x8), .y(y8), .in_valid(in_valid8), .in_ready(in_ready8),
        .o(o8), .out_valid(out_valid8), .out_ready(out_ready8), .busy(busy8)
    );

    function automatic longint unsigned ref_prod(input longint unsigned a,
                                                 input longint unsigned b, input int w);
        longint          sa, sb;
        longint unsigned mask;
        mask = (64'd1 << (2 * w)) - 64'd1;
        sa   = longint'(a);
        sb   = longint'(b);
`ifdef PIPE_MULT_SIGNED_EN
        if (a[w-1]) sa = sa - (64'sd1 <<< w);
        if (b[w-1]) sb = sb - (64'sd1 <<< w);
`endif
        return longint'(sa * sb) & mask;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks += 8;
        if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_ov4: got %b want 0", out_valid4); end
        if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4: got %b want 0", busy4); end
        if (o4 !== 8'h00) begin errors++; $display("FAIL reset_o4: got %h want 00", o4); end
        if (in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_ir4: got %b want 1", in_ready4); end
        if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_ov8: got %b want 0", out_valid8); end
        if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b want 0", busy8); end
        if (o8 !== 16'h0000) begin errors++; $display("FAIL reset_o8: got %h want 0000", o8); end
        if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_ir8: got %b want 1", in_ready8); end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_single();
        cyc();
        x4 = 4'd3; y4 = 4'd5; in_valid4 = 1'b1; out_ready4 = 1'b1;
        cyc();
        in_valid4 = 1'b0;
        @(negedge clk);
        checks += 2;
        if (out_valid4 !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", out_valid4); end
        if (busy4 !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy4); end
        cyc();
        @(negedge clk);
        checks += 2;
        if (out_valid4 !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid4); end
        if (o4 !== 8'h0F) begin errors++; $display("FAIL single_o: got %h want 0f", o4); end
        cyc();
        @(negedge clk);
        checks += 2;
        if (out_valid4 !== 1'b0) begin errors++; $display("FAIL single_once: got %b want 0", out_valid4); end
        if (busy4 !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy4); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e1, e2;
        e1 = 8'(ref_prod(15, 15, 4));
        e2 = 8'(ref_prod(0, 9, 4));
        cyc();
        x4 = 4'd15; y4 = 4'd15; in_valid4 = 1'b1; out_ready4 = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready4 !== 1'b1) begin errors++; $display("FAIL b2b_ir0: got %b want 1", in_ready4); end
        cyc();
        x4 = 4'd0; y4 = 4'd9;
        @(negedge clk);
        checks++;
        if (in_ready4 !== 1'b1) begin errors++; $display("FAIL b2b_ir1: got %b want 1", in_ready4); end
        cyc();
        in_valid4 = 1'b0;
        @(negedge clk);
        checks += 2;
        if (out_valid4 !== 1'b1) begin errors++; $display("FAIL b2b_v1: got %b want 1", out_valid4); end
        if (o4 !== e1) begin errors++; $display("FAIL b2b_o1: got %h want %h", o4, e1); end
        cyc();
        @(negedge clk);
        checks += 2;
        if (out_valid4 !== 1'b1) begin errors++; $display("FAIL b2b_v2: got %b want 1", out_valid4); end
        if (o4 !== e2) begin errors++; $display("FAIL b2b_o2: got %h want %h", o4, e2); end
        cyc();
        @(negedge clk);
        checks++;
        if (out_valid4 !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", out_valid4); end
    endtask

    task automatic test_stall();
        logic [3:0] a, b, c, d;
        logic [7:0] eab, ecd;
        a = 4'($urandom_range(15, 0)); b = 4'($urandom_range(15, 0));
        c = 4'($urandom_range(15, 0)); d = 4'($urandom_range(15, 0));
        eab = 8'(ref_prod(a, b, 4));
        ecd = 8'(ref_prod(c, d, 4));
        cyc();
        x4 = a; y4 = b; in_valid4 = 1'b1; out_ready4 = 1'b1;
        cyc();
        x4 = c; y4 = d;
        cyc();
        x4 = 4'($urandom_range(15, 0)); y4 = 4'($urandom_range(15, 0));
        out_ready4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 3;
            if (in_ready4 !== 1'b0) begin errors++; $display("FAIL stall_ir[%0d]: got %b want 0", i, in_ready4); end
            if (out_valid4 !== 1'b1) begin errors++; $display("FAIL stall_v[%0d]: got %b want 1", i, out_valid4); end
            if (o4 !== eab) begin errors++; $display("FAIL stall_o[%0d]: got %h want %h", i, o4, eab); end
            cyc();
        end
        out_ready4 = 1'b1; in_valid4 = 1'b0;
        @(negedge clk);
        checks += 2;
        if (in_ready4 !== 1'b1) begin errors++; $display("FAIL stall_release_ir: got %b want 1", in_ready4); end
        if (o4 !== eab) begin errors++; $display("FAIL stall_drain1: got %h want %h", o4, eab); end
        cyc();
        @(negedge clk);
        checks += 2;
        if (out_valid4 !== 1'b1) begin errors++; $display("FAIL stall_v2: got %b want 1", out_valid4); end
        if (o4 !== ecd) begin errors++; $display("FAIL stall_drain2: got %h want %h", o4, ecd); end
        cyc();
        @(negedge clk);
        checks++;
        if (out_valid4 !== 1'b0) begin errors++; $display("FAIL stall_extra: got %b want 0", out_valid4); end
    endtask

    task automatic test_reset_midflight();
        cyc();
        x4 = 4'd7; y4 = 4'd6; in_valid4 = 1'b1; out_ready4 = 1'b1;
        cyc();
        x4 = 4'd5; y4 = 4'd5;
        cyc();
        in_valid4 = 1'b0;
        rst = 1'b1;
        #1;
        checks += 4;
        if (out_valid4 !== 1'b0) begin errors++; $display("FAIL rstmid_ov: got %b want 0", out_valid4); end
        if (busy4 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy4); end
        if (o4 !== 8'h00) begin errors++; $display("FAIL rstmid_o: got %h want 00", o4); end
        if (in_ready4 !== 1'b1) begin errors++; $display("FAIL rstmid_ir: got %b want 1", in_ready4); end
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid4 !== 1'b0) begin errors++; $display("FAIL rstmid_stale[%0d]: got %b want 0", i, out_valid4); end
            cyc();
        end
    endtask

    task automatic test_sign_mode();
        logic [7:0] want;
`ifdef PIPE_MULT_SIGNED_EN
        want = 8'hC8;
`else
        want = 8'h38;
`endif
        cyc();
        x4 = 4'h8; y4 = 4'h7; in_valid4 = 1'b1; out_ready4 = 1'b1;
        cyc();
        in_valid4 = 1'b0;
        cyc();
        @(negedge clk);
        checks += 2;
        if (out_valid4 !== 1'b1) begin errors++; $display("FAIL sign_v: got %b want 1", out_valid4); end
        if (o4 !== want) begin errors++; $display("FAIL sign_o: got %h want %h", o4, want); end
    endtask

    // Unstalled traffic: each product must appear exactly LAT8 cycles after acceptance.
    task automatic test_latency8(input int n_ops);
        int     sent, n;
        entry_t e;
        sent = 0; n = 0;
        q.delete();
        out_ready8 = 1'b1;
        while ((sent < n_ops || q.size() > 0) && n < 4 * n_ops + 50) begin
            cyc();
            in_valid8 = (sent < n_ops) && ($urandom_range(3, 0) != 0);
            x8 = 8'($urandom_range(255, 0)); y8 = 8'($urandom_range(255, 0));
            @(negedge clk);
            n++;
            if (out_valid8) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL lat_spurious: got o=%h want no output", o8);
                end else begin
                    e = q.pop_front();
                    if (e.due != n || o8 !== e.p) begin
                        errors++;
                        $display("FAIL lat_out: got o=%h at %0d want %h at %0d", o8, n, e.p, e.due);
                    end
                end
            end else if (q.size() > 0 && q[0].due <= n) begin
                checks++; errors++;
                e = q.pop_front();
                $display("FAIL lat_missing: got no output at %0d want %h", n, e.p);
            end
            if (in_valid8 && in_ready8) begin
                e.p = 16'(ref_prod(x8, y8, 8)); e.due = n + LAT8;
                q.push_back(e);
                sent++;
            end
        end
        in_valid8 = 1'b0;
        checks++;
        if (sent != n_ops || q.size() != 0) begin
            errors++; $display("FAIL lat_count: got sent=%0d left=%0d want %0d/0", sent, q.size(), n_ops);
        end
    endtask

    // Random in_valid/out_ready: in-order, lossless, duplicate-free delivery and hold under stall.
    task automatic test_random_stall8(input int n_ops);
        int          sent, n;
        entry_t      e;
        logic        held;
        logic [15:0] held_o;
        sent = 0; n = 0; held = 1'b0; held_o = '0;
        q.delete();
        while ((sent < n_ops || q.size() > 0) && n < 8 * n_ops + 100) begin
            cyc();
            in_valid8  = (sent < n_ops) && ($urandom_range(1, 0) != 0);
            out_ready8 = ($urandom_range(2, 0) != 0);
            x8 = 8'($urandom_range(255, 0)); y8 = 8'($urandom_range(255, 0));
            @(negedge clk);
            n++;
            checks++;
            if (in_ready8 !== (!out_valid8 || out_ready8)) begin
                errors++; $display("FAIL rnd_ir: got %b want %b", in_ready8, !out_valid8 || out_ready8);
            end
            if (held) begin
                checks++;
                if (out_valid8 !== 1'b1 || o8 !== held_o) begin
                    errors++; $display("FAIL rnd_hold: got v=%b o=%h want v=1 o=%h", out_valid8, o8, held_o);
                end
            end
            if (out_valid8 && out_ready8) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_dup: got o=%h want no output", o8);
                end else begin
                    e = q.pop_front();
                    if (o8 !== e.p) begin errors++; $display("FAIL rnd_out: got %h want %h", o8, e.p); end
                end
            end
            held   = out_valid8 && !out_ready8;
            held_o = o8;
            if (in_valid8 && in_ready8) begin
                e.p = 16'(ref_prod(x8, y8, 8)); e.due = 0;
                q.push_back(e);
                sent++;
            end
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        checks++;
        if (sent != n_ops || q.size() != 0) begin
            errors++; $display("FAIL rnd_count: got sent=%0d left=%0d want %0d/0", sent, q.size(), n_ops);
        end
        repeat (LAT8 + 1) cyc();
        @(negedge clk);
        checks += 2;
        if (out_valid8 !== 1'b0) begin errors++; $display("FAIL rnd_tail_v: got %b want 0", out_valid8); end
        if (busy8 !== 1'b0) begin errors++; $display("FAIL rnd_tail_busy: got %b want 0", busy8); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_sign_mode();
        test_latency8(300);
        test_random_stall8(700);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_multiplier.md
PIPE_MULTIPLIER -- requirements
Module: pipe_multiplier

Interface
REQ-001 SHALL provide parameter WIDTH, default 4: operand width in bits, legal range 2..32.
REQ-002 SHALL provide parameter STAGES, default 2: number of register stages, which equals latency in cycles; legal range 1..4.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 x  input  WIDTH  multiplicand.
REQ-006 y  input  WIDTH  multiplier.
REQ-007 in_valid  input  1  x/y valid this cycle.
REQ-008 in_ready  output  1  block accepts x/y this cycle.
REQ-009 o  output  2*WIDTH  product.
REQ-010 out_valid  output  1  o holds a valid product.
REQ-011 out_ready  input  1  consumer accepts o this cycle.
REQ-012 busy  output  1  high while any stage holds a valid entry.

Function
REQ-013 Partial products SHALL be x[i]&y[j], reduced with half/full-adder compression and a final carry-propagate add; the product is exact modulo 2^(2*WIDTH), so no overflow is possible.
REQ-014 The reduction SHALL be split across STAGES register stages, each carrying a valid bit; balance of logic between stages is implementation-defined.
REQ-015 Advance condition: adv = !out_valid || out_ready, global to the pipeline.
REQ-016 in_ready SHALL equal adv, combinationally; no dependency on in_valid.
REQ-017 On adv, every stage loads its predecessor; stage 0 loads x/y and valid = in_valid.
REQ-018 When adv is low, all stages and o SHALL hold their values unchanged.
REQ-019 Transfer in occurs on in_valid && in_ready; transfer out occurs on out_valid && out_ready.
REQ-020 An unstalled operand accepted at edge n SHALL produce out_valid at edge n+STAGES-1, observable for the following cycle; throughput is one product per cycle.
REQ-021 Simultaneous accept and emit in the same cycle SHALL lose no data and duplicate no data.
REQ-022 Bubbles (in_valid low) SHALL propagate as invalid entries; o is don't-care while out_valid is low.
REQ-023 Products SHALL leave in acceptance order.
REQ-024 busy = OR of all stage valid bits.

Reset
REQ-025 While rst is high: all valid bits = 0, o = 0, out_valid = 0, busy = 0; in_ready = 1 as a consequence of REQ-015.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight entries; no product from before reset may appear afterwards.
REQ-027 Data registers other than o need not be reset.

Configuration
REQ-028 Macro PIPE_MULT_SIGNED_EN: when defined, x, y and o SHALL be two's complement, using Baugh-Wooley or sign-extended partial products.
REQ-029 Without PIPE_MULT_SIGNED_EN, x, y and o SHALL be unsigned.
REQ-030 Timing, handshake and reset behaviour SHALL be identical in both builds.

Verification (WIDTH=4, STAGES=2 unless noted)
REQ-031 x=3, y=5, in_valid for 1 cycle, out_ready=1 -> o=8'h0F, out_valid high exactly one cycle, 2 cycles after accept.
REQ-032 x=15, y=15 then x=0, y=9 back-to-back, out_ready=1 -> o=8'hE1 then 8'h00 on consecutive cycles; in_ready held at 1.
REQ-033 Product pending, out_ready=0 for 3 cycles, in_valid=1 -> in_ready=0 and o/out_valid held; out_ready=1 -> results drain in order, nothing lost.
REQ-034 rst pulsed while 2 entries in flight -> out_valid=0, busy=0, o=0 immediately; no stale product afterwards.
REQ-035 PIPE_MULT_SIGNED_EN defined, x=4'h8 (-8), y=4'h7 -> o=8'hC8 (-56); unsigned build, same inputs -> o=8'h38.
REQ-036 WIDTH=8, STAGES=3, 1000 random operands with random in_valid/out_ready -> every product matches the reference model, in order, latency 3 when unstalled.
